ewrapper_io_tx_gearbox: RTL and testbench
=========================================

# ewrapper_io_tx_gearbox

Parametrised eLink transmit gearbox: accepts one CH×W-bit parallel word per handshake and emits it as per-channel even/odd bit pairs, one pair per fast clock, for the downstream ODDR stage. Runs entirely in the fast TX clock domain. A valid/ready handshake with a one-word holding buffer replaces slow-clock edge detection. Adds seamless back-to-back streaming, idle insertion with underrun accounting, word-start marking and polarity inversion.

## Interface

Parameters
- CH, 9: number of serial channels (8 data + frame by default)
- W, 8: bits per channel per word; even, ≥2
- CNT_W, 16: underrun counter width

Ports
- CLK_IN  input  1  fast TX clock (ODDR clock)
- IO_RESET_N  input  1  asynchronous, active-low reset
- elink_invert  input  1  invert all data bits; sampled at word transfer
- elink_disable  input  1  synchronous flush/hold-off
- tx_data  input  CH*W  channel c in tx_data[c*W +: W], MSB transmitted first
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  holding buffer can accept
- dout_even  output  CH  bit for ODDR D1, registered
- dout_odd  output  CH  bit for ODDR D2, registered
- word_start  output  1  dout carries pair 0 of a word
- tx_active  output  1  dout carries word data (not idle)
- underrun  output  1  one-cycle pulse when a word ends with no successor
- underrun_cnt  output  CNT_W  saturating underrun count

## Operation

- State: hold register + hold_full; shift register (CH*W); rem = pairs remaining in shifter (0..W/2-1).
- Accept: tx_valid & tx_ready at an edge → hold <= tx_data, hold_full <= 1.
- tx_ready = ~elink_disable & (~hold_full | rem==0). Combinational from state only, never from tx_valid.
- xfer = hold_full & rem==0 & ~elink_disable. On xfer:
  - dout_even[c] <= bit W-1 and dout_odd[c] <= bit W-2 of channel c, each XOR elink_invert.
  - Shifter <= remaining bits, also XOR elink_invert.
  - rem <= W/2-1; word_start <= 1; tx_active <= 1.
  - hold_full <= 0, unless a new word is accepted on the same edge.
- rem>0: dout <= next pair from shifter top; rem--; word_start <= 0.
- rem==0 & ~hold_full: dout <= {CH{elink_invert}} (idle, logical 0); tx_active <= 0; word_start <= 0.
  - If tx_active was 1, underrun pulses for one cycle and underrun_cnt increments, saturating at all-ones.
  - Idle-to-idle never counts.
- elink_disable=1 at an edge:
  - hold_full <= 0, rem <= 0, dout <= idle, tx_active <= 0, word_start <= 0.
  - Current word aborted; no underrun counted.
- W=2: every word is a single pair; a continuous tx_valid gives one word per cycle.

## Timing

- Reset (IO_RESET_N=0, asynchronous):
  - dout_even=dout_odd=0, word_start=0, tx_active=0, underrun=0, underrun_cnt=0.
  - hold_full=0, rem=0, shifter=0.
  - tx_ready = ~elink_disable.
- Latency: word accepted at edge k, with shifter empty → pair 0 on dout after edge k+1 (word_start=1); last pair after edge k+W/2.
- Throughput: one word per W/2 cycles. A successor held by edge k+W/2-1 streams with no gap, no idle and no underrun.
- Simultaneous accept and xfer on one edge are legal; hold ends full with the new word.
- Reset release mid-stream requires no recovery sequence; the first accepted word is sent intact.

## Test plan

- Reset, CH=9, W=8: present tx_data channel0=0xA5, others 0, tx_valid for one handshake → after the next edge dout_even[0],dout_odd[0] = (1,0),(1,0),(0,1),(0,1) over 4 cycles; word_start only on the first; underrun pulse on cycle 5; underrun_cnt=1.
- Two words 0xFF…, 0x00… back-to-back with tx_valid held → 8 contiguous data cycles; word_start on cycles 1 and 5; tx_active constant 1; one underrun after cycle 8.
- elink_invert=1, word 0xA5 on channel0 → pairs (0,1),(0,1),(1,0),(1,0); idle output all ones.
- elink_disable asserted on the 2nd pair of a word with a second word held → next cycle dout idle, tx_ready=0, tx_active=0, underrun=0, count unchanged; after deassert, a new word transmits intact.
- CNT_W=2: five isolated words, each followed by idle → underrun_cnt sequence 1,2,3,3,3.
- W=2, CH=3: tx_valid held with incrementing data → tx_ready constant 1, a new word on dout every cycle, word_start constant 1, no underrun until tx_valid drops.

Source files
------------

// File: rtl/ewrapper_io_tx_gearbox.sv
// ewrapper_io_tx_gearbox
//
// eLink transmit gearbox in the fast TX clock domain. The gearbox takes one
// CH*W-bit parallel word per valid/ready handshake into a one-word holding
// buffer. It then serialises each channel as even/odd bit pairs, one pair per
// clock, for the downstream ODDR stage. Channel c occupies tx_data[c*W +: W]
// and is sent MSB first. A word waiting in the holding buffer streams with no
// gap. When no successor word is ready, the output goes idle and an underrun
// is counted.
//
// Ports
//   CLK_IN        fast TX clock (ODDR clock)
//   IO_RESET_N    asynchronous active-low reset
//   elink_invert  invert all data bits; sampled when a word moves to the shifter
//   elink_disable synchronous flush / hold-off
//   tx_data       CH*W parallel word
//   tx_valid      tx_data valid
//   tx_ready      holding buffer can accept (depends on state and disable only)
//   dout_even     per-channel bit for ODDR D1 (registered)
//   dout_odd      per-channel bit for ODDR D2 (registered)
//   word_start    dout carries pair 0 of a word
//   tx_active     dout carries word data (not idle)
//   underrun      one-cycle pulse when a word ends with no successor
//   underrun_cnt  saturating underrun count

module ewrapper_io_tx_gearbox #(
    parameter int CH    = 9,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                CLK_IN,
    input  logic                IO_RESET_N,
    input  logic                elink_invert,
    input  logic                elink_disable,
    input  logic [CH*W-1:0]     tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [CH-1:0]       dout_even,
    output logic [CH-1:0]       dout_odd,
    output logic                word_start,
    output logic                tx_active,
    output logic                underrun,
    output logic [CNT_W-1:0]    underrun_cnt
);

    localparam int NP    = W / 2;
    localparam int REM_W = (NP > 1) ? $clog2(NP) : 1;

    logic [CH*W-1:0]  hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CH*W-1:0]  shift_q, shift_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CH-1:0]    even_q, even_d;
    logic [CH-1:0]    odd_q, odd_d;
    logic             ws_q, ws_d;
    logic             act_q, act_d;
    logic             ur_q, ur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rem_zero;
    logic             accept;
    logic             xfer;
    logic [CH*W-1:0]  word_inv;
    logic [CH*W-1:0]  hold_sh;
    logic [CH*W-1:0]  shift_sh;
    logic [CH-1:0]    hold_e, hold_o;
    logic [CH-1:0]    shift_e, shift_o;

    assign rem_zero = (rem_q == '0);
    // Ready is a function of state and disable only, so no combinational
    // path exists from tx_valid back to tx_ready.
    assign tx_ready = ~elink_disable & (~hold_full_q | rem_zero);
    assign accept   = tx_valid & tx_ready;
    assign xfer     = hold_full_q & rem_zero & ~elink_disable;

    // Inversion is applied once as the word enters the shifter. A word that is
    // already in flight keeps the polarity it started with.
    assign word_inv = hold_q ^ {(CH*W){elink_invert}};

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign hold_e[c]             = word_inv[c*W + W - 1];
        assign hold_o[c]             = word_inv[c*W + W - 2];
        assign hold_sh[c*W +: W]     = word_inv[c*W +: W] << 2;
        assign shift_e[c]            = shift_q[c*W + W - 1];
        assign shift_o[c]            = shift_q[c*W + W - 2];
        assign shift_sh[c*W +: W]    = shift_q[c*W +: W] << 2;
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        even_d      = even_q;
        odd_d       = odd_q;
        ws_d        = 1'b0;
        act_d       = act_q;
        ur_d        = 1'b0;
        cnt_d       = cnt_q;

        if (accept) begin
            hold_d = tx_data;
        end

        if (elink_disable) begin
            // Flush: the word in flight is dropped and no underrun is counted.
            hold_full_d = 1'b0;
            rem_d       = '0;
            even_d      = {CH{elink_invert}};
            odd_d       = {CH{elink_invert}};
            act_d       = 1'b0;
        end else begin
            // A new word may be accepted on the same edge that the old one moves out.
            if (accept) begin
                hold_full_d = 1'b1;
            end else if (xfer) begin
                hold_full_d = 1'b0;
            end

            if (xfer) begin
                even_d  = hold_e;
                odd_d   = hold_o;
                shift_d = hold_sh;
                rem_d   = REM_W'(NP - 1);
                ws_d    = 1'b1;
                act_d   = 1'b1;
            end else if (!rem_zero) begin
                even_d  = shift_e;
                odd_d   = shift_o;
                shift_d = shift_sh;
                rem_d   = rem_q - REM_W'(1);
            end else begin
                // Idle drives logical 0 on the line.
                even_d = {CH{elink_invert}};
                odd_d  = {CH{elink_invert}};
                act_d  = 1'b0;
                if (act_q) begin
                    ur_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge IO_RESET_N) begin
        if (!IO_RESET_N) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            rem_q       <= '0;
            even_q      <= '0;
            odd_q       <= '0;
            ws_q        <= 1'b0;
            act_q       <= 1'b0;
            ur_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            even_q      <= even_d;
            odd_q       <= odd_d;
            ws_q        <= ws_d;
            act_q       <= act_d;
            ur_q        <= ur_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dout_even    = even_q;
    assign dout_odd     = odd_q;
    assign word_start   = ws_q;
    assign tx_active    = act_q;
    assign underrun     = ur_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_ewrapper_io_tx_gearbox.sv
module tb_ewrapper_io_tx_gearbox;

    // Main instance: CH=9, W=8, CNT_W=16
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inv, dis, v;
    logic [71:0] d;
    logic        rdy, ws, act, ur;
    logic [8:0]  e, o;
    logic [15:0] cnt;

    // Small instance: CH=3, W=2, CNT_W=2
    logic        s_inv, s_dis, s_v;
    logic [5:0]  s_d;
    logic        s_rdy, s_ws, s_act, s_ur;
    logic [2:0]  s_e, s_o;
    logic [1:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ewrapper_io_tx_gearbox #(.CH(9), .W(8), .CNT_W(16)) dut (
        .CLK_IN(clk), .IO_RESET_N(rst_n), .elink_invert(inv), .elink_disable(dis),
        .tx_data(d), .tx_valid(v), .tx_ready(rdy), .dout_even(e), .dout_odd(o),
        .word_start(ws), .tx_active(act), .underrun(ur), .underrun_cnt(cnt)
    );

    ewrapper_io_tx_gearbox #(.CH(3), .W(2), .CNT_W(2)) dut_s (
        .CLK_IN(clk), .IO_RESET_N(rst_n), .elink_invert(s_inv), .elink_disable(s_dis),
        .tx_data(s_d), .tx_valid(s_v), .tx_ready(s_rdy), .dout_even(s_e), .dout_odd(s_o),
        .word_start(s_ws), .tx_active(s_act), .underrun(s_ur), .underrun_cnt(s_cnt)
    );

    typedef struct {
        logic        v;
        logic        inv;
        logic        dis;
        logic [71:0] d;
        logic        rdy;
        logic [8:0]  e;
        logic [8:0]  o;
        logic        ws;
        logic        act;
        logic        ur;
        logic [15:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [8:0] e;
        logic [8:0] o;
        logic       ws;
    } pair_t;

    vec_t  tbl[35];
    pair_t sbq[$];

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [71:0] w);
        pair_t p;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 9; c++) begin
                p.e[c] = w[c*8 + 7 - 2*k];
                p.o[c] = w[c*8 + 6 - 2*k];
            end
            p.ws = (k == 0);
            sbq.push_back(p);
        end
    endtask

    localparam logic [71:0] ONES = {72{1'b1}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // v inv dis data rdy even odd ws act ur cnt
        tbl[0]  = '{1, 0, 0, 72'hA5, 1, 9'h000, 9'h000, 0, 0, 0, 16'd0};
        tbl[1]  = '{0, 0, 0, 72'h0,  1, 9'h001, 9'h000, 1, 1, 0, 16'd0};
        tbl[2]  = '{0, 0, 0, 72'h0,  1, 9'h001, 9'h000, 0, 1, 0, 16'd0};
        tbl[3]  = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h001, 0, 1, 0, 16'd0};
        tbl[4]  = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h001, 0, 1, 0, 16'd0};
        tbl[5]  = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 1, 16'd1};
        tbl[6]  = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 0, 16'd1};
        tbl[7]  = '{1, 0, 0, ONES,   1, 9'h000, 9'h000, 0, 0, 0, 16'd1};
        tbl[8]  = '{1, 0, 0, 72'h0,  1, 9'h1FF, 9'h1FF, 1, 1, 0, 16'd1};
        tbl[9]  = '{0, 0, 0, 72'h0,  0, 9'h1FF, 9'h1FF, 0, 1, 0, 16'd1};
        tbl[10] = '{0, 0, 0, 72'h0,  0, 9'h1FF, 9'h1FF, 0, 1, 0, 16'd1};
        tbl[11] = '{0, 0, 0, 72'h0,  0, 9'h1FF, 9'h1FF, 0, 1, 0, 16'd1};
        tbl[12] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 1, 1, 0, 16'd1};
        tbl[13] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 1, 0, 16'd1};
        tbl[14] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 1, 0, 16'd1};
        tbl[15] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 1, 0, 16'd1};
        tbl[16] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 1, 16'd2};
        tbl[17] = '{1, 1, 0, 72'hA5, 1, 9'h1FF, 9'h1FF, 0, 0, 0, 16'd2};
        tbl[18] = '{0, 1, 0, 72'h0,  1, 9'h1FE, 9'h1FF, 1, 1, 0, 16'd2};
        tbl[19] = '{0, 1, 0, 72'h0,  1, 9'h1FE, 9'h1FF, 0, 1, 0, 16'd2};
        tbl[20] = '{0, 1, 0, 72'h0,  1, 9'h1FF, 9'h1FE, 0, 1, 0, 16'd2};
        tbl[21] = '{0, 1, 0, 72'h0,  1, 9'h1FF, 9'h1FE, 0, 1, 0, 16'd2};
        tbl[22] = '{0, 1, 0, 72'h0,  1, 9'h1FF, 9'h1FF, 0, 0, 1, 16'd3};
        tbl[23] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 0, 16'd3};
        tbl[24] = '{1, 0, 0, 72'hA5, 1, 9'h000, 9'h000, 0, 0, 0, 16'd3};
        tbl[25] = '{1, 0, 0, 72'h3C, 1, 9'h001, 9'h000, 1, 1, 0, 16'd3};
        tbl[26] = '{0, 0, 0, 72'h0,  0, 9'h001, 9'h000, 0, 1, 0, 16'd3};
        tbl[27] = '{0, 0, 1, 72'h0,  0, 9'h000, 9'h000, 0, 0, 0, 16'd3};
        tbl[28] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 0, 16'd3};
        tbl[29] = '{1, 0, 0, 72'h96, 1, 9'h000, 9'h000, 0, 0, 0, 16'd3};
        tbl[30] = '{0, 0, 0, 72'h0,  1, 9'h001, 9'h000, 1, 1, 0, 16'd3};
        tbl[31] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h001, 0, 1, 0, 16'd3};
        tbl[32] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h001, 0, 1, 0, 16'd3};
        tbl[33] = '{0, 0, 0, 72'h0,  1, 9'h001, 9'h000, 0, 1, 0, 16'd3};
        tbl[34] = '{0, 0, 0, 72'h0,  1, 9'h000, 9'h000, 0, 0, 1, 16'd4};

        rst_n = 1'b0;
        inv = 1'b0; dis = 1'b0; v = 1'b0; d = '0;
        s_inv = 1'b0; s_dis = 1'b0; s_v = 1'b0; s_d = '0;

        // Reset state
        #12;
        chk("rst_even", e, 0);
        chk("rst_odd", o, 0);
        chk("rst_ws", ws, 0);
        chk("rst_active", act, 0);
        chk("rst_underrun", ur, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", rdy, 1);
        dis = 1'b1;
        #1;
        chk("rst_ready_disabled", rdy, 0);
        dis = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table: single word, streaming pair, inversion, disable flush
        for (int i = 0; i < 35; i++) begin
            v = tbl[i].v; inv = tbl[i].inv; dis = tbl[i].dis; d = tbl[i].d;
            #1;
            chk($sformatf("t%0d_ready", i), rdy, tbl[i].rdy);
            tick();
            chk($sformatf("t%0d_even", i), e, tbl[i].e);
            chk($sformatf("t%0d_odd", i), o, tbl[i].o);
            chk($sformatf("t%0d_ws", i), ws, tbl[i].ws);
            chk($sformatf("t%0d_active", i), act, tbl[i].act);
            chk($sformatf("t%0d_underrun", i), ur, tbl[i].ur);
            chk($sformatf("t%0d_cnt", i), cnt, tbl[i].cnt);
        end

        // Asynchronous reset in the middle of a word
        v = 1'b1; inv = 1'b0; dis = 1'b0; d = ONES;
        tick();
        v = 1'b0; d = '0;
        tick();
        chk("mid_pre_active", act, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_even", e, 0);
        chk("async_rst_odd", o, 0);
        chk("async_rst_active", act, 0);
        chk("async_rst_cnt", cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Scoreboard: continuous then random traffic; first word after reset must be intact
        for (int cyc = 0; cyc < 220; cyc++) begin
            if (act === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_unexpected: got active data %0h/%0h, required idle", e, o);
                end else begin
                    pair_t p;
                    p = sbq.pop_front();
                    chk("sb_even", e, p.e);
                    chk("sb_odd", o, p.o);
                    chk("sb_ws", ws, p.ws);
                end
            end
            if (cyc >= 2 && cyc <= 40) begin
                chk("stream_active", act, 1);
                chk("stream_no_underrun", ur, 0);
            end
            if (cyc < 40) v = 1'b1;
            else if (cyc < 200) v = ($urandom_range(0, 2) == 0);
            else v = 1'b0;
            d = 72'({$urandom, $urandom, $urandom});
            #1;
            if (v && rdy) push_word(d);
            tick();
        end
        v = 1'b0;
        for (int n = 0; n < 40 && sbq.size() > 0; n++) begin
            if (act === 1'b1) begin
                pair_t p;
                p = sbq.pop_front();
                chk("sb_even", e, p.e);
                chk("sb_odd", o, p.o);
                chk("sb_ws", ws, p.ws);
            end
            tick();
        end
        chk("sb_drain_left", sbq.size(), 0);

        // W=2 instance: saturating counter with isolated words
        begin
            int exp_sat[5];
            exp_sat = '{1, 2, 3, 3, 3};
            for (int k = 0; k < 5; k++) begin
                logic [5:0] w;
                logic [2:0] pe, po;
                w = 6'(k * 13 + 5);
                for (int c = 0; c < 3; c++) begin
                    pe[c] = w[2*c + 1];
                    po[c] = w[2*c];
                end
                s_v = 1'b1; s_d = w;
                tick();
                s_v = 1'b0;
                tick();
                chk("sat_even", s_e, pe);
                chk("sat_odd", s_o, po);
                chk("sat_ws", s_ws, 1);
                tick();
                chk("sat_underrun", s_ur, 1);
                chk("sat_cnt", s_cnt, exp_sat[k]);
                tick();
            end
        end

        // W=2 instance: one word per cycle with tx_valid held
        begin
            logic [5:0] prev;
            prev = '0;
            for (int i = 0; i < 12; i++) begin
                s_v = 1'b1; s_d = 6'(i + 20);
                #1;
                chk("w2_ready", s_rdy, 1);
                tick();
                if (i >= 1) begin
                    chk("w2_even", s_e, {prev[5], prev[3], prev[1]});
                    chk("w2_odd", s_o, {prev[4], prev[2], prev[0]});
                    chk("w2_ws", s_ws, 1);
                    chk("w2_active", s_act, 1);
                    chk("w2_underrun", s_ur, 0);
                end
                prev = 6'(i + 20);
            end
            s_v = 1'b0;
            tick();
            chk("w2_last_even", s_e, {prev[5], prev[3], prev[1]});
            chk("w2_last_ws", s_ws, 1);
            chk("w2_last_underrun", s_ur, 0);
            tick();
            chk("w2_end_underrun", s_ur, 1);
            chk("w2_end_active", s_act, 0);
            chk("w2_end_cnt", s_cnt, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
